// File: rtl/key_press_classifier_if.sv
// rtl/key_press_classifier_if.sv - key event inputs and gesture pulse outputs of the classifier
interface key_press_classifier_if;
    logic key_press;
    logic key_level;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic busy;

    // Debouncer / stimulus side: drives key events, observes gesture pulses.
    modport master (
        output key_press,
        output key_level,
        input  short_pulse,
        input  double_pulse,
        input  long_pulse,
        input  busy
    );

    // Classifier side.
    modport slave (
        input  key_press,
        input  key_level,
        output short_pulse,
        output double_pulse,
        output long_pulse,
        output busy
    );
endinterface

// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - classifies debounced key gestures into short, double and long presses
module key_press_classifier #(
    parameter int CNT_W         = 26,
    parameter int LONG_CYCLES   = 50000000,
    parameter int DCLICK_CYCLES = 15000000
) (
    input  logic                  clk,
    input  logic                  rst,
    key_press_classifier_if.slave kif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;

    // Saturating increment so the timer can never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // State, timer and registered pulse outputs; reset discards any gesture in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    // Next-state logic; every transition clears the timer, pulses default low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (kif.key_press) begin
                    state_d = PRESS1;
                end
            end
            PRESS1: begin
                // Release wins over the long threshold landing in the same cycle.
                if (!kif.key_level) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HOLD;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LONG_HOLD: begin
                if (!kif.key_level) begin
                    state_d = IDLE;
                end
            end
            WAIT2: begin
                // A second press wins over the timeout landing in the same cycle.
                if (kif.key_press) begin
                    state_d = PRESS2;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESS2: begin
                if (!kif.key_level) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign kif.short_pulse  = short_q;
    assign kif.double_pulse = double_q;
    assign kif.long_pulse   = long_q;
    assign kif.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - table-driven gesture checks for key_press_classifier
module tb_key_press_classifier;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_press_classifier_if kif ();

    key_press_classifier #(
        .CNT_W         (8),
        .LONG_CYCLES   (20),
        .DCLICK_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    // One gesture run: press cycles, key_level high windows, reset cycle,
    // expected pulse cycles, first cycle with busy low, and run length.
    // A value of -1 means "none".
    typedef struct {
        int pr0;
        int pr1;
        int on0;
        int off0;
        int on1;
        int off1;
        int rs;
        int es0;
        int es1;
        int ed;
        int el;
        int bf;
        int len;
    } vec_t;

    vec_t tv [9];
    int   checks = 0;
    int   errors = 0;

    initial begin
        //          pr0 pr1 on0 off0 on1 off1  rs  es0 es1  ed  el  bf len
        tv[0] = '{   5, -1,  6,   9, -1,  -1, -1,  21, -1, -1, -1, 21, 40}; // single short
        tv[1] = '{   5, -1,  6,  60, -1,  -1, -1,  -1, -1, -1, 26, 62, 70}; // long press
        tv[2] = '{   5, 14,  6,   9, 14,  17, -1,  -1, -1, 19, -1, 19, 40}; // double click
        tv[3] = '{   5, 20,  6,   9, 20,  23, -1,  -1, -1, 25, -1, 25, 40}; // press on timeout cycle
        tv[4] = '{   5, 22,  6,   9, 23,  26, -1,  21, 38, -1, -1, 21, 50}; // new gesture after short
        tv[5] = '{   5, -1,  6,  24, -1,  -1, -1,  36, -1, -1, -1, 36, 45}; // release on threshold
        tv[6] = '{   5, -1,  6,  60, -1,  -1, 10,  -1, -1, -1, -1, 11, 70}; // reset in PRESS1
        tv[7] = '{   5, -1,  6,   9, -1,  -1, 15,  -1, -1, -1, -1, 16, 40}; // reset in WAIT2
        tv[8] = '{   5, -1,  6,  60, -1,  -1, 40,  -1, -1, -1, 26, 41, 70}; // reset in LONG_HOLD

        kif.key_press = 1'b0;
        kif.key_level = 1'b0;

        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c <= tv[v].len; c++) begin
                logic [2:0] exp_p;
                logic [2:0] act_p;
                @(negedge clk);
                // Outputs now reflect the edge that closed cycle c-1.
                if (c >= 2) begin
                    exp_p = {(c == tv[v].es0) || (c == tv[v].es1),
                             (c == tv[v].ed),
                             (c == tv[v].el)};
                    act_p = {kif.short_pulse, kif.double_pulse, kif.long_pulse};
                    checks++;
                    if (act_p !== exp_p) begin
                        errors++;
                        $display("FAIL pulses vec%0d cyc%0d: got {s,d,l}=%b want %b", v, c, act_p, exp_p);
                    end
                    if (c == 2 || c == tv[v].bf) begin
                        checks++;
                        if (kif.busy !== 1'b0) begin
                            errors++;
                            $display("FAIL busy_low vec%0d cyc%0d: got %b want 0", v, c, kif.busy);
                        end
                    end
                    if (c == tv[v].bf - 1) begin
                        checks++;
                        if (kif.busy !== 1'b1) begin
                            errors++;
                            $display("FAIL busy_high vec%0d cyc%0d: got %b want 1", v, c, kif.busy);
                        end
                    end
                end
                // Inputs for cycle c, sampled at the next rising edge.
                rst           = (c < 2) || (c == tv[v].rs);
                kif.key_press = (c == tv[v].pr0) || (c == tv[v].pr1);
                kif.key_level = ((c >= tv[v].on0) && (c <= tv[v].off0)) ||
                                ((c >= tv[v].on1) && (c <= tv[v].off1));
            end
            kif.key_press = 1'b0;
            kif.key_level = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
